// File: rtl/rp_decouple_ctrl.sv
// Shutdown/decouple controller for a reconfigurable partition.
// Drains AXI-Stream channels to frame boundaries and the RP AXI slave to zero
// outstanding bursts, blocks all boundary traffic, then acknowledges. Also
// throttles AR/AW issue at MAX_OUTSTANDING and bounds the drain with a timeout.
module rp_decouple_ctrl #(
  parameter int unsigned NUM_STREAMS     = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shutdown_req,
  output logic                   shutdown_ack,
  output logic                   active,
  output logic                   timeout,
  output logic                   axi_err,
  input  logic [NUM_STREAMS-1:0] st_tvalid,
  input  logic [NUM_STREAMS-1:0] st_tready,
  input  logic [NUM_STREAMS-1:0] st_tlast,
  output logic [NUM_STREAMS-1:0] st_block,
  input  logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic                   axi_rvalid,
  input  logic                   axi_rready,
  input  logic                   axi_rlast,
  input  logic                   axi_awvalid,
  input  logic                   axi_awready,
  input  logic                   axi_bvalid,
  input  logic                   axi_bready,
  output logic                   axi_ar_block,
  output logic                   axi_aw_block
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = 32;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DECOUPLED = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_STREAMS-1:0] in_frame, in_frame_nxt, beat, st_block_nxt;
  logic [CW-1:0]          rd_cnt, rd_cnt_nxt, wr_cnt, wr_cnt_nxt;
  logic [TW-1:0]          timer, timer_nxt;
  logic                   timeout_nxt, axi_err_nxt;
  logic                   ar_block_nxt, aw_block_nxt;
  logic                   rd_inc, rd_dec, wr_inc, wr_dec;
  logic                   drained, expired;

  // Frame tracking and outstanding-burst counters; these run in every state
  always_comb begin
    beat         = st_tvalid & st_tready;
    in_frame_nxt = (beat & ~st_tlast) | (~beat & in_frame);
    rd_inc       = axi_arvalid & axi_arready;
    rd_dec       = axi_rvalid & axi_rready & axi_rlast;
    wr_inc       = axi_awvalid & axi_awready;
    wr_dec       = axi_bvalid & axi_bready;
    rd_cnt_nxt   = rd_cnt;
    wr_cnt_nxt   = wr_cnt;
    axi_err_nxt  = axi_err;
    if (rd_inc && !rd_dec) begin
      rd_cnt_nxt = rd_cnt + CW'(1);
    end else if (rd_dec && !rd_inc) begin
      if (rd_cnt == '0) axi_err_nxt = 1'b1;
      else              rd_cnt_nxt  = rd_cnt - CW'(1);
    end
    if (wr_inc && !wr_dec) begin
      wr_cnt_nxt = wr_cnt + CW'(1);
    end else if (wr_dec && !wr_inc) begin
      if (wr_cnt == '0) axi_err_nxt = 1'b1;
      else              wr_cnt_nxt  = wr_cnt - CW'(1);
    end
  end

  // Next-state and next-output logic; abort beats done, done beats timeout
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    timeout_nxt  = timeout;
    st_block_nxt = '0;
    drained      = (&st_block) && (rd_cnt == '0) && (wr_cnt == '0);
    expired      = (TIMEOUT_CYCLES != 0) && (timer == TW'(TIMEOUT_CYCLES - 1));
    case (state)
      ST_ACTIVE: begin
        if (shutdown_req) begin
          state_nxt    = ST_DRAIN;
          timer_nxt    = '0;
          timeout_nxt  = 1'b0;
          st_block_nxt = ~in_frame_nxt;
        end
      end
      ST_DRAIN: begin
        if (!shutdown_req) begin
          state_nxt = ST_ACTIVE;
        end else if (drained) begin
          state_nxt    = ST_DECOUPLED;
          st_block_nxt = '1;
        end else if (expired) begin
          state_nxt    = ST_DECOUPLED;
          timeout_nxt  = 1'b1;
          st_block_nxt = '1;
        end else begin
          timer_nxt    = timer + TW'(1);
          st_block_nxt = st_block | ~in_frame_nxt;
        end
      end
      ST_DECOUPLED: begin
        if (!shutdown_req) state_nxt    = ST_ACTIVE;
        else               st_block_nxt = '1;
      end
      default: state_nxt = ST_ACTIVE;
    endcase
    ar_block_nxt = (state_nxt != ST_ACTIVE) || (rd_cnt_nxt == CW'(MAX_OUTSTANDING));
    aw_block_nxt = (state_nxt != ST_ACTIVE) || (wr_cnt_nxt == CW'(MAX_OUTSTANDING));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACTIVE;
    else     state <= state_nxt;
  end

  // Tracking registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame     <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      timer        <= '0;
      active       <= 1'b1;
      shutdown_ack <= 1'b0;
      timeout      <= 1'b0;
      axi_err      <= 1'b0;
      st_block     <= '0;
      axi_ar_block <= 1'b0;
      axi_aw_block <= 1'b0;
    end else begin
      in_frame     <= in_frame_nxt;
      rd_cnt       <= rd_cnt_nxt;
      wr_cnt       <= wr_cnt_nxt;
      timer        <= timer_nxt;
      active       <= (state_nxt == ST_ACTIVE);
      shutdown_ack <= (state_nxt == ST_DECOUPLED);
      timeout      <= timeout_nxt;
      axi_err      <= axi_err_nxt;
      st_block     <= st_block_nxt;
      axi_ar_block <= ar_block_nxt;
      axi_aw_block <= aw_block_nxt;
    end
  end

endmodule

// File: tb/tb_rp_decouple_ctrl.sv
// Scoreboard bench for rp_decouple_ctrl: the driver pushes the hand-computed
// expected outputs for each cycle, a monitor pops and compares after each edge.
module tb_rp_decouple_ctrl;

  localparam int unsigned NS = 4;

  logic          clk = 1'b0;
  logic          rst, shutdown_req, shutdown_ack, active, timeout, axi_err;
  logic [NS-1:0] st_tvalid, st_tready, st_tlast, st_block;
  logic          axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic          axi_awvalid, axi_awready, axi_bvalid, axi_bready;
  logic          axi_ar_block, axi_aw_block;

  typedef struct {
    string         name;
    bit            chk;
    logic          act, ack, to, err;
    logic [NS-1:0] sb;
    logic          arb, awb;
  } exp_t;

  exp_t E;
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  rp_decouple_ctrl #(.NUM_STREAMS(NS), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .shutdown_req(shutdown_req), .shutdown_ack(shutdown_ack),
    .active(active), .timeout(timeout), .axi_err(axi_err),
    .st_tvalid(st_tvalid), .st_tready(st_tready), .st_tlast(st_tlast), .st_block(st_block),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_rlast(axi_rlast), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_ar_block(axi_ar_block), .axi_aw_block(axi_aw_block)
  );

  always #5 clk = ~clk;

  task automatic clear_handshakes();
    st_tvalid = '0; st_tready = '0; st_tlast = '0;
    axi_arvalid = 0; axi_arready = 0; axi_rvalid = 0; axi_rready = 0; axi_rlast = 0;
    axi_awvalid = 0; axi_awready = 0; axi_bvalid = 0; axi_bready = 0;
  endtask

  // Push the expectation for the coming edge, then advance one cycle
  task automatic step(input string nm, input bit chk);
    exp_t e;
    e = E; e.name = nm; e.chk = chk;
    sbq.push_back(e);
    @(negedge clk);
    clear_handshakes();
  endtask

  task automatic beat(input int s, input logic last);
    st_tvalid[s] = 1'b1; st_tready[s] = 1'b1; st_tlast[s] = last;
  endtask

  task automatic exp_idle();
    E.act = 1; E.ack = 0; E.sb = '0; E.arb = 0; E.awb = 0;
  endtask
  task automatic exp_drain(input logic [NS-1:0] sb);
    E.act = 0; E.ack = 0; E.sb = sb; E.arb = 1; E.awb = 1;
  endtask
  task automatic exp_decoupled();
    E.act = 0; E.ack = 1; E.sb = '1; E.arb = 1; E.awb = 1;
  endtask

  // Monitor: compare every expectation one step after its clock edge
  initial begin
    exp_t e;
    logic [10:0] got, req;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          got = {active, shutdown_ack, timeout, axi_err, st_block, axi_ar_block, axi_aw_block};
          req = {e.act, e.ack, e.to, e.err, e.sb, e.arb, e.awb};
          total++;
          if (got !== req) begin
            bad++;
            $display("FAIL %s: got act/ack/to/err/sb/arb/awb=%b required %b", e.name, got, req);
          end
        end
      end
    end
  end

  // Driver: directed vectors with hand-computed expectations
  initial begin
    clear_handshakes();
    rst = 1; shutdown_req = 0;
    E.to = 0; E.err = 0; exp_idle();
    @(negedge clk);
    step("reset0", 1);
    step("reset1", 1);
    rst = 0;
    step("idle", 1);

    // Idle shutdown: blocks one cycle after req, ack one cycle later
    shutdown_req = 1; exp_drain('1);     step("t1_drain", 1);
    exp_decoupled();                     step("t1_ack", 1);
                                         step("t1_hold", 1);
    shutdown_req = 0; exp_idle();        step("t1_release", 1);

    // Stream0 mid-frame: three more beats after req
    beat(0, 0);                          step("t2_open", 1);
    shutdown_req = 1; beat(0, 0); exp_drain(4'b1110); step("t2_drain", 1);
    beat(0, 0);                          step("t2_mid", 1);
    beat(0, 1); exp_drain(4'b1111);      step("t2_blk0", 1);
    exp_decoupled();                     step("t2_ack", 1);
    shutdown_req = 0; exp_idle();        step("t2_release", 1);

    // Two outstanding reads; AR+rlast together keeps the count
    axi_arvalid = 1; axi_arready = 1;    step("t3_ar1", 1);
    axi_arvalid = 1; axi_arready = 1; E.arb = 1; step("t3_throttle", 1);
    shutdown_req = 1; axi_arvalid = 1; axi_arready = 1;
    axi_rvalid = 1; axi_rready = 1; axi_rlast = 1; exp_drain('1); step("t3_drain", 1);
    axi_rvalid = 1; axi_rready = 1; axi_rlast = 1; step("t3_wait1", 1);
    axi_rvalid = 1; axi_rready = 1;      step("t3_nolast", 1);
    axi_rvalid = 1; axi_rready = 1; axi_rlast = 1; step("t3_wait2", 1);
    exp_decoupled();                     step("t3_ack", 1);
    shutdown_req = 0; exp_idle();        step("t3_release", 1);

    // Stream1 stuck in frame: timeout after 16 drain cycles
    beat(1, 0);                          step("t4_open", 1);
    shutdown_req = 1; exp_drain(4'b1101); step("t4_drain", 1);
    for (int i = 0; i < 15; i++) step("t4_pre", i == 14);
    exp_decoupled(); E.to = 1;           step("t4_timeout", 1);
    shutdown_req = 0; exp_idle();        step("t4_sticky", 1);
    beat(1, 1);                          step("t4_close", 1);
    shutdown_req = 1; exp_drain('1); E.to = 0; step("t4_toclr", 1);
    exp_decoupled();                     step("t4_ack", 1);
    shutdown_req = 0; exp_idle();        step("t4_release", 1);

    // Abort during drain
    beat(2, 0);                          step("t5_open", 1);
    shutdown_req = 1; exp_drain(4'b1011); step("t5_drain", 1);
    shutdown_req = 0; exp_idle();        step("t5_abort", 1);
    beat(2, 1);                          step("t5_close", 1);

    // Write throttle and underflow error
    axi_awvalid = 1; axi_awready = 1;    step("t6_aw1", 1);
    axi_awvalid = 1; axi_awready = 1; E.awb = 1; step("t6_throttle", 1);
    axi_bvalid = 1; axi_bready = 1; E.awb = 0; step("t6_b1", 1);
    axi_bvalid = 1; axi_bready = 1;      step("t6_b2", 1);
    axi_bvalid = 1; axi_bready = 1; E.err = 1; step("t6_err", 1);
                                         step("t6_err_sticky", 1);

    // Reset in the middle of a drain
    shutdown_req = 1; exp_drain('1);     step("t7_drain", 1);
    rst = 1; E.err = 0; E.to = 0; exp_idle(); step("t7_rst", 1);
    rst = 0; shutdown_req = 0;           step("t7_after", 1);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
